// File: rtl/bus_unpack_ser_8_pkg.sv
// Shared stopwatch definitions: FSM state encoding and divider width helper.
package bus_unpack_ser_8_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_unpack_ser_8_bit_period_cnt.sv
// Reloadable bit-period divider: counts 0..Cycles-1 while enabled and flags the last count.
module bit_period_cnt
  import bus_unpack_ser_8_pkg::*;
#(
  parameter int unsigned Cycles = 4,
  parameter int unsigned Width  = cnt_width(Cycles)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] Last = Width'(Cycles - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  // With Cycles=1 the count stays at zero and tc_o is permanently high.
  assign tc_o = (cnt_q == Last);

  // Clear has priority; otherwise wrap to zero on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_unpack_ser_8.sv
// Byte unpacker/serialiser: fans a handshaken byte out to eight registered wires
// and shifts it out one bit per BIT_CYCLES clocks with valid and done strobes.
module bus_unpack_ser_8
  import bus_unpack_ser_8_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LVL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       abort_i,
  output logic       out0_o,
  output logic       out1_o,
  output logic       out2_o,
  output logic       out3_o,
  output logic       out4_o,
  output logic       out5_o,
  output logic       out6_o,
  output logic       out7_o,
  output logic       ser_out_o,
  output logic       ser_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned DivW = cnt_width(BIT_CYCLES);

  state_e     state_q;
  logic [7:0] sr_q;
  logic [7:0] out_q;
  logic [2:0] idx_q;
  logic       ser_q, ser_valid_q, busy_q, done_q;

  logic       accept, bit_end;
  logic [7:0] sr_next;
  logic       ser_next, first_bit;

  assign in_ready_o = (state_q == StIdle) && !abort_i;
  assign accept     = in_valid_i && in_ready_o;

  // Shift direction selects which end of the register feeds the pin.
  always_comb begin
    first_bit = LSB_FIRST ? in_data_i[0] : in_data_i[7];
    sr_next   = LSB_FIRST ? {1'b0, sr_q[7:1]} : {sr_q[6:0], 1'b0};
    ser_next  = LSB_FIRST ? sr_q[1] : sr_q[6];
  end

  bit_period_cnt #(
    .Cycles (BIT_CYCLES),
    .Width  (DivW)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept || abort_i),
    .en_i  (state_q == StShift),
    .tc_o  (bit_end)
  );

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      ser_q       <= IDLE_LVL;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StShift;
            sr_q        <= in_data_i;
            out_q       <= in_data_i;
            idx_q       <= '0;
            ser_q       <= first_bit;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StShift: begin
          if (abort_i) begin
            // Cancelled frames end silently; out_q keeps the aborted byte.
            state_q     <= StIdle;
            ser_q       <= IDLE_LVL;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (bit_end) begin
            if (idx_q != 3'd7) begin
              sr_q  <= sr_next;
              idx_q <= idx_q + 3'd1;
              ser_q <= ser_next;
            end else begin
              state_q     <= StIdle;
              ser_q       <= IDLE_LVL;
              ser_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign {out7_o, out6_o, out5_o, out4_o, out3_o, out2_o, out1_o, out0_o} = out_q;
  assign ser_out_o   = ser_q;
  assign ser_valid_o = ser_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_bus_unpack_ser_8.sv
// Bench for bus_unpack_ser_8: two instances (BIT_CYCLES=4 LSB-first, BIT_CYCLES=1 MSB-first)
// checked every cycle against a frame-timing model, plus table and directed sequences.
module tb_bus_unpack_ser_8;

  localparam int unsigned BcA  = 4;
  localparam bit          LsbA = 1'b1;
  localparam int unsigned BcB  = 1;
  localparam bit          LsbB = 1'b0;
  localparam bit          Idle = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       va = 1'b0, aa = 1'b0, vb = 1'b0, ab = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic       ra, sa, sva, ba, dna;
  logic       rb, sb, svb, bb, dnb;
  logic [7:0] oa, ob;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_unpack_ser_8 #(.BIT_CYCLES(BcA), .LSB_FIRST(LsbA), .IDLE_LVL(Idle)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data_i(da), .in_valid_i(va), .in_ready_o(ra),
    .abort_i(aa), .out0_o(oa[0]), .out1_o(oa[1]), .out2_o(oa[2]), .out3_o(oa[3]),
    .out4_o(oa[4]), .out5_o(oa[5]), .out6_o(oa[6]), .out7_o(oa[7]), .ser_out_o(sa),
    .ser_valid_o(sva), .busy_o(ba), .done_o(dna)
  );

  bus_unpack_ser_8 #(.BIT_CYCLES(BcB), .LSB_FIRST(LsbB), .IDLE_LVL(Idle)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data_i(db), .in_valid_i(vb), .in_ready_o(rb),
    .abort_i(ab), .out0_o(ob[0]), .out1_o(ob[1]), .out2_o(ob[2]), .out3_o(ob[3]),
    .out4_o(ob[4]), .out5_o(ob[5]), .out6_o(ob[6]), .out7_o(ob[7]), .ser_out_o(sb),
    .ser_valid_o(svb), .busy_o(bb), .done_o(dnb)
  );

  // Frame model: cnt is the number of cycles already spent inside the current frame.
  typedef struct {
    bit         active;
    int         cnt;
    logic [7:0] data;
    logic [7:0] outs;
    bit         done;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.active = 1'b0; m.cnt = 0; m.data = '0; m.outs = '0; m.done = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input int bc, input logic v,
                                        input logic [7:0] d, input logic abt);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (m.active) begin
      if (abt) n.active = 1'b0;
      else if (m.cnt == 8 * bc - 1) begin
        n.active = 1'b0;
        n.done   = 1'b1;
      end else n.cnt = m.cnt + 1;
    end else if (v && !abt) begin
      n.active = 1'b1; n.cnt = 0; n.data = d; n.outs = d;
    end
    return n;
  endfunction

  function automatic logic model_ser(input model_t m, input int bc, input bit lsb);
    int         pos;
    logic [7:0] tmp;
    if (!m.active) return Idle;
    pos = lsb ? (m.cnt / bc) : 7 - (m.cnt / bc);
    tmp = m.data >> pos;
    return tmp[0];
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk1("a_ready", ra, !ma.active && !aa);
    chk1("a_busy", ba, ma.active);
    chk1("a_ser_valid", sva, ma.active);
    chk1("a_ser_out", sa, model_ser(ma, BcA, LsbA));
    chk1("a_done", dna, ma.done);
    chk8("a_outs", oa, ma.outs);
    chk1("b_ready", rb, !mb.active && !ab);
    chk1("b_busy", bb, mb.active);
    chk1("b_ser_valid", svb, mb.active);
    chk1("b_ser_out", sb, model_ser(mb, BcB, LsbB));
    chk1("b_done", dnb, mb.done);
    chk8("b_outs", ob, mb.outs);
  endtask

  task automatic tick();
    @(posedge clk);
    ma = model_step(ma, BcA, va, da, aa);
    mb = model_step(mb, BcB, vb, db, ab);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       abt;
    logic       e_busy;
    logic       e_ser;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    logic [7:0] obs;
    int         done_cyc, sv_cnt, rise_cyc, dn_cnt;
    logic       sv_prev;

    ma = model_reset();
    mb = model_reset();

    // Expected per-edge results for 8'h3C on the MSB-first, one-clock-per-bit instance.
    seq = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tbl[i].v       = (i == 0);
      tbl[i].d       = (i == 0) ? 8'h3C : 8'h00;
      tbl[i].abt     = 1'b0;
      tbl[i].e_busy  = (i < 8);
      tbl[i].e_ser   = (i < 8) ? seq[7-i] : Idle;
      tbl[i].e_done  = (i == 8);
      tbl[i].e_ready = (i >= 8);
    end

    // Reset defaults.
    #12 rst_n = 1'b1;
    #1;
    check_all();
    chk1("rst_ready", ra, 1'b1);
    chk8("rst_outs", oa, 8'h00);
    chk1("rst_ser", sa, 1'b0);

    // Table-driven MSB-first frame.
    for (int i = 0; i < 10; i++) begin
      vb = tbl[i].v; db = tbl[i].d; ab = tbl[i].abt;
      tick();
      chk1("tbl_busy", bb, tbl[i].e_busy);
      chk1("tbl_ser", sb, tbl[i].e_ser);
      chk1("tbl_done", dnb, tbl[i].e_done);
      chk1("tbl_ready", rb, tbl[i].e_ready);
    end

    // LSB-first A5 frame with 4 clocks per bit; in_valid wiggles mid-frame.
    va = 1'b1; da = 8'hA5;
    tick();
    done_cyc = -1; sv_cnt = 0; obs = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      if (c == 1) chk8("a5_outs", oa, 8'hA5);
      if (sva) sv_cnt++;
      if (dna && done_cyc < 0) done_cyc = c;
      if (c <= 32 && ((c - 1) % 4) == 0) obs[(c - 1) / 4] = sa;
      if (c == 33) chk1("a5_ready_at_done", ra, 1'b1);
      va = (c < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
      da = 8'($urandom);
    end
    chk_int("a5_done_cycle", done_cyc, 33);
    chk_int("a5_valid_cycles", sv_cnt, 32);
    chk8("a5_bits", obs, 8'hA5);

    // Back-to-back on the one-clock instance: second byte taken on the done cycle.
    vb = 1'b1; db = 8'h01;
    tick();
    db = 8'h80;
    done_cyc = -1; rise_cyc = -1; sv_prev = svb;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (dnb && done_cyc < 0) done_cyc = c;
      if (svb && !sv_prev && rise_cyc < 0) rise_cyc = c;
      if (c == 10) chk8("b2b_second_outs", ob, 8'h80);
      sv_prev = svb;
    end
    chk_int("b2b_done_cycle", done_cyc, 9);
    chk_int("b2b_second_start", rise_cyc, 10);
    vb = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    // Abort of an FF frame at cycle 10.
    va = 1'b1; da = 8'hFF;
    tick();
    va = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    aa = 1'b1;
    tick();
    chk1("abort_ser_valid", sva, 1'b0);
    chk1("abort_ser_out", sa, Idle);
    chk8("abort_outs", oa, 8'hFF);
    aa = 1'b0;
    dn_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dna) dn_cnt++;
    end
    chk_int("abort_no_done", dn_cnt, 0);
    aa = 1'b1; va = 1'b1; da = 8'h12;
    tick();
    chk1("abort_idle_no_accept", ba, 1'b0);
    chk8("abort_idle_outs", oa, 8'hFF);
    aa = 1'b0; va = 1'b0;
    tick();

    // Asynchronous reset dropped between edges at cycle 13.
    va = 1'b1; da = 8'($urandom); vb = 1'b1; db = 8'($urandom);
    tick();
    va = 1'b0; vb = 1'b0;
    for (int c = 2; c <= 13; c++) tick();
    #3 rst_n = 1'b0;
    #1;
    ma = model_reset();
    mb = model_reset();
    check_all();
    chk1("async_busy_a", ba, 1'b0);
    chk8("async_outs_a", oa, 8'h00);
    #2 rst_n = 1'b1;
    dn_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dna || dnb) dn_cnt++;
    end
    chk_int("async_no_done", dn_cnt, 0);

    // Randomised traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      va = ($urandom_range(0, 3) == 0); da = 8'($urandom);
      aa = ($urandom_range(0, 31) == 0);
      vb = ($urandom_range(0, 3) == 0); db = 8'($urandom);
      ab = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_unpack_ser_8.md
Name: bus_unpack_ser_8

Overview:
- Inverse of the stopwatch bit-gather tap: takes an 8-bit bus through a valid/ready handshake.
- Fans the captured byte back out to eight individual registered wires.
- Shifts the same byte out serially, one bit per BIT_CYCLES clocks, with a valid strobe and an end-of-frame pulse.
- Sits between the stopwatch core's packed buses and single-wire consumers: LED pins, a shift-register display driver, or a debug serial pin.

Parameters:
- BIT_CYCLES, 4: clocks each serial bit is held; legal range 1..65535.
- LSB_FIRST, 1: 1 = bit 0 is shifted first; 0 = bit 7 first.
- IDLE_LVL, 0: level driven on ser_out whenever ser_valid=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to unpack and serialise.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a byte this cycle.
- abort  in  1  synchronous cancel of the frame in progress.
- out0..out7  out  1 each  registered copy of in_data[0]..in_data[7] from the last accepted byte.
- ser_out  out  1  serial data.
- ser_valid  out  1  high while ser_out carries a frame bit.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last bit period of a frame.

Behaviour:
- Reset and clock: one clock domain, clk. rst_n is asynchronous and active-low: it clears all state immediately; release is synchronous to clk.
- Reset values:
  - state=IDLE, shift register=0, bit index=0, divider count=0.
  - out0..out7=0, ser_out=IDLE_LVL, ser_valid=0, busy=0, done=0.
  - in_ready=1 once rst_n is high (it is combinational).
- in_ready = (state==IDLE) && !abort; it is the only combinational output.
- States:
  - IDLE: accept occurs when in_valid && in_ready at a clock edge.
  - SHIFT: entered on accept.
  - IDLE is re-entered after the last bit period or on abort.
- On accept (edge k):
  - Latch in_data into the shift register and into out0..out7.
  - Set busy=1, ser_valid=1, bit index=0, divider=0.
  - Drive ser_out = in_data[0] (LSB_FIRST=1) or in_data[7] (LSB_FIRST=0).
  - All of these are visible in the cycle after edge k. Latency accept-to-first-bit = 1 clock.
- In SHIFT:
  - The divider counts 0..BIT_CYCLES-1.
  - At count BIT_CYCLES-1 with bit index<7: shift one position, increment the index, reset the divider.
  - At count BIT_CYCLES-1 with bit index==7: go to IDLE, set ser_valid=0, busy=0, ser_out=IDLE_LVL, done=1 for exactly one cycle.
- Frame timing:
  - ser_valid is high for exactly 8*BIT_CYCLES consecutive cycles.
  - in_ready rises in the same cycle done is high.
  - Minimum spacing: one idle cycle between frames, i.e. a back-to-back period of 8*BIT_CYCLES+1 clocks.
- in_data and in_valid are ignored while in_ready=0. out0..out7 hold their value until the next accept; they are not cleared at frame end.
- abort high at an edge in SHIFT: go to IDLE, set ser_valid=0, busy=0, ser_out=IDLE_LVL. done is NOT pulsed; out0..out7 keep the aborted byte.
- abort and in_valid together in IDLE: abort wins, no accept, no state change.
- abort in IDLE with in_valid low: no effect.
- BIT_CYCLES=1: one bit per clock; the divider never counts; timing rules unchanged.
- Divider width = clog2(BIT_CYCLES), minimum 1 bit. Bit index is 3 bits with no wrap past 7.
- rst_n asserted mid-frame: immediately return to reset values, no done, partial frame discarded.

Decomposition:
- Shared stopwatch package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the clog2 helper function used for the divider width.
- One sub-module is natural: bit_period_cnt, a reloadable divider with a terminal-count output, reusable by the display scanner.
- The shift register, FSM and output registers stay in bus_unpack_ser_8.

Test Plan:
- Reset defaults: rst_n low, then high. Expect in_ready=1, out0..7=0, ser_out=0, ser_valid=0, busy=0, done=0.
- LSB-first frame, BIT_CYCLES=4: send in_data=8'hA5. Expect the following; done pulses 1 cycle at cycle 33, in_ready=1 at cycle 33.
  - out7..out0 = 1,0,1,0,0,1,0,1 from cycle 1.
  - ser_out sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - ser_valid high cycles 1-32.
- MSB-first, BIT_CYCLES=1: send 8'h3C. Expect ser_out 0,0,1,1,1,1,0,0 on cycles 1-8, done at cycle 9.
- Back-to-back, BIT_CYCLES=1: hold in_valid=1 with 8'h01 then 8'h80.
  - The second byte is accepted when done=1.
  - Its first bit appears 10 cycles after the first accept.
  - in_valid toggling mid-frame has no effect.
- Abort: send 8'hFF, assert abort at cycle 10. Expect ser_valid=0 and ser_out=IDLE_LVL next cycle, no done, out0..7 still 1. abort+in_valid together in IDLE yields no accept.
- Async reset mid-frame: drop rst_n between clock edges at cycle 13. Expect all outputs at reset values without waiting for an edge, no done after release.
